// File: rtl/recovery_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// recovery_sequencer_pkg : shared sizes, FSM state type and map-table packet
// Revision 1.0
// ============================================================================
package recovery_sequencer_pkg;

    localparam int SYS_XLEN                = 32;
    localparam int SYS_PHYS_REG_ADDR_WIDTH = 6;
    localparam int SYS_ARCH_REGS           = 32;
    localparam int SYS_REC_LANES           = 4;

    typedef enum logic [2:0] {
        REC_IDLE     = 3'd0,
        REC_SQUASH   = 3'd1,
        REC_RESTORE  = 3'd2,
        REC_DRAIN    = 3'd3,
        REC_REDIRECT = 3'd4,
        REC_HALTED   = 3'd5
    } REC_STATE;

    typedef struct packed {
        logic                                               en;
        logic [$clog2(SYS_ARCH_REGS)-1:0]                   base;
        logic [SYS_REC_LANES*SYS_PHYS_REG_ADDR_WIDTH-1:0]   data;
    } MT_RESTORE_PACKET;

endpackage
`default_nettype wire

// File: rtl/recovery_sequencer.sv
`default_nettype none
// ============================================================================
// recovery_sequencer : squash -> chunked map-table restore -> SQ drain -> redirect
// Revision 1.0
// ============================================================================
module recovery_sequencer
    import recovery_sequencer_pkg::*;
#(
    parameter int ARCH_REGS = SYS_ARCH_REGS,
    parameter int PREG_W    = SYS_PHYS_REG_ADDR_WIDTH,
    parameter int LANES     = SYS_REC_LANES,
    parameter int XLEN      = SYS_XLEN
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          rec_req_i,
    input  logic [XLEN-1:0]               rec_pc_i,
    input  logic [ARCH_REGS*PREG_W-1:0]   ckpt_tbl_i,
    input  logic                          halt_in_i,
    input  logic                          sq_drain_busy_i,
    output logic                          squash_o,
    output logic                          stall_dispatch_o,
    output logic                          mt_wr_en_o,
    output logic [$clog2(ARCH_REGS)-1:0]  mt_wr_base_o,
    output logic [LANES*PREG_W-1:0]       mt_wr_data_o,
    output logic                          redirect_valid_o,
    output logic [XLEN-1:0]               redirect_pc_o,
    output logic                          busy_o,
    output logic                          halted_o
);

    localparam int CHUNKS = ARCH_REGS / LANES;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int IDX_W  = $clog2(ARCH_REGS);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

    REC_STATE                     state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [XLEN-1:0]              snap_pc_q;
    logic [ARCH_REGS*PREG_W-1:0]  snap_tbl_q;
    logic                         squash_q;
    logic                         stall_q;
    logic                         mt_wr_en_q;
    logic [IDX_W-1:0]             mt_wr_base_q;
    logic [LANES*PREG_W-1:0]      mt_wr_data_q;
    logic                         redirect_valid_q;
    logic [XLEN-1:0]              redirect_pc_q;
    logic                         busy_q;
    logic                         halted_q;

    logic [CNT_W-1:0]             cnt_d;
    logic [IDX_W-1:0]             base_d;
    logic [LANES*PREG_W-1:0]      chunk_d;

    // Chunk presented on the next cycle: 0 when leaving SQUASH, else counter+1.
    // Entries are contiguous in the snapshot, so a chunk is a single slice.
    always_comb begin
        cnt_d   = (state_q == REC_RESTORE) ? cnt_q + 1'b1 : '0;
        base_d  = IDX_W'(int'(cnt_d) * LANES);
        chunk_d = snap_tbl_q[int'(base_d) * PREG_W +: LANES * PREG_W];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q          <= REC_IDLE;
            cnt_q            <= '0;
            snap_pc_q        <= '0;
            snap_tbl_q       <= '0;
            squash_q         <= 1'b0;
            stall_q          <= 1'b0;
            mt_wr_en_q       <= 1'b0;
            mt_wr_base_q     <= '0;
            mt_wr_data_q     <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
            halted_q         <= 1'b0;
        end else begin
            squash_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state_q)
                REC_IDLE: begin
                    // A recovery outranks a same-cycle halt.
                    if (rec_req_i) begin
                        snap_pc_q  <= rec_pc_i;
                        snap_tbl_q <= ckpt_tbl_i;
                        state_q    <= REC_SQUASH;
                        squash_q   <= 1'b1;
                        stall_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (halt_in_i) begin
                        state_q    <= REC_HALTED;
                        stall_q    <= 1'b1;
                        halted_q   <= 1'b1;
                    end
                end
                REC_SQUASH: begin
                    state_q      <= REC_RESTORE;
                    cnt_q        <= '0;
                    mt_wr_en_q   <= 1'b1;
                    mt_wr_base_q <= base_d;
                    mt_wr_data_q <= chunk_d;
                end
                REC_RESTORE: begin
                    if (cnt_q == LAST_CHUNK) begin
                        state_q      <= REC_DRAIN;
                        cnt_q        <= '0;
                        mt_wr_en_q   <= 1'b0;
                        mt_wr_base_q <= '0;
                        mt_wr_data_q <= '0;
                    end else begin
                        cnt_q        <= cnt_d;
                        mt_wr_base_q <= base_d;
                        mt_wr_data_q <= chunk_d;
                    end
                end
                REC_DRAIN: begin
                    if (!sq_drain_busy_i) begin
                        state_q          <= REC_REDIRECT;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= snap_pc_q;
                    end
                end
                REC_REDIRECT: begin
                    state_q <= REC_IDLE;
                    stall_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                REC_HALTED: begin
                    state_q <= REC_HALTED;
                end
                default: begin
                    state_q <= REC_IDLE;
                    stall_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign squash_o         = squash_q;
    assign stall_dispatch_o = stall_q;
    assign mt_wr_en_o       = mt_wr_en_q;
    assign mt_wr_base_o     = mt_wr_base_q;
    assign mt_wr_data_o     = mt_wr_data_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign busy_o           = busy_q;
    assign halted_o         = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_recovery_sequencer.sv
`default_nettype none
// ============================================================================
// tb_recovery_sequencer : directed checks of the recovery sequencer
// Revision 1.0
// ============================================================================
module tb_recovery_sequencer;

    localparam int ARCH_REGS = 32;
    localparam int PREG_W    = 6;
    localparam int LANES     = 4;
    localparam int XLEN      = 32;
    localparam int TBL_W     = ARCH_REGS * PREG_W;
    localparam int CHK_W     = LANES * PREG_W;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               rec_req = 1'b0;
    logic [XLEN-1:0]    rec_pc = '0;
    logic [TBL_W-1:0]   ckpt_tbl = '0;
    logic               halt_in = 1'b0;
    logic               sq_drain_busy = 1'b0;
    logic               squash;
    logic               stall_dispatch;
    logic               mt_wr_en;
    logic [4:0]         mt_wr_base;
    logic [CHK_W-1:0]   mt_wr_data;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               busy;
    logic               halted;

    int checks   = 0;
    int failures = 0;

    recovery_sequencer #(
        .ARCH_REGS(ARCH_REGS), .PREG_W(PREG_W), .LANES(LANES), .XLEN(XLEN)
    ) u_dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .rec_req_i       (rec_req),
        .rec_pc_i        (rec_pc),
        .ckpt_tbl_i      (ckpt_tbl),
        .halt_in_i       (halt_in),
        .sq_drain_busy_i (sq_drain_busy),
        .squash_o        (squash),
        .stall_dispatch_o(stall_dispatch),
        .mt_wr_en_o      (mt_wr_en),
        .mt_wr_base_o    (mt_wr_base),
        .mt_wr_data_o    (mt_wr_data),
        .redirect_valid_o(redirect_valid),
        .redirect_pc_o   (redirect_pc),
        .busy_o          (busy),
        .halted_o        (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".squash"},   64'(squash),         64'd0);
        check({tag, ".stall"},    64'(stall_dispatch), 64'd0);
        check({tag, ".wr_en"},    64'(mt_wr_en),       64'd0);
        check({tag, ".wr_base"},  64'(mt_wr_base),     64'd0);
        check({tag, ".wr_data"},  64'(mt_wr_data),     64'd0);
        check({tag, ".redir_v"},  64'(redirect_valid), 64'd0);
        check({tag, ".redir_pc"}, 64'(redirect_pc),    64'd0);
        check({tag, ".busy"},     64'(busy),           64'd0);
        check({tag, ".halted"},   64'(halted),         64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Expected restore chunk k when table entry i holds (i + ofs) mod 64.
    function automatic logic [CHK_W-1:0] exp_chunk(input int k, input int ofs);
        logic [CHK_W-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++)
            v[l*PREG_W +: PREG_W] = PREG_W'(k*LANES + l + ofs);
        return v;
    endfunction

    function automatic logic [TBL_W-1:0] make_tbl(input int ofs);
        logic [TBL_W-1:0] t;
        t = '0;
        for (int i = 0; i < ARCH_REGS; i++)
            t[i*PREG_W +: PREG_W] = PREG_W'(i + ofs);
        return t;
    endfunction

    // Runs one recovery from IDLE, cycle 0 being the rec_req cycle.
    // sq_drain_busy is high in cycles dlo..dhi; a spurious request with
    // different pc/table is raised in cycle reqc.
    task automatic run_seq(input string tag, input logic [XLEN-1:0] pc, input int ofs,
                           input int dlo, input int dhi, input int reqc, input logic halt_too,
                           output int rcyc, output int nred, output logic [XLEN-1:0] rpc,
                           output int nstall_low, output int nwr, output int nhalt,
                           output logic [CHK_W-1:0] first_data, output logic busy_after,
                           output logic [XLEN-1:0] pc_after);
        int nsq;
        rcyc = -1; nred = 0; rpc = '0; nstall_low = 0; nwr = 0; nhalt = 0; nsq = 0;
        first_data = '0; busy_after = 1'b1; pc_after = '0;
        ckpt_tbl = make_tbl(ofs);
        rec_pc   = pc;
        rec_req  = 1'b1;
        halt_in  = halt_too;
        sq_drain_busy = (dlo <= 0 && dhi >= 0);
        tick();
        rec_req = 1'b0;
        halt_in = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (squash) begin
                nsq++;
                check({tag, ".squash_cycle"}, 64'(c), 64'd1);
            end
            if (mt_wr_en) begin
                if (nwr == 0) first_data = mt_wr_data;
                check({tag, ".wr_base"}, 64'(mt_wr_base), 64'(nwr * LANES));
                check({tag, ".wr_data"}, 64'(mt_wr_data), 64'(exp_chunk(nwr, ofs)));
                nwr++;
            end
            if (redirect_valid) begin
                nred++;
                if (nred == 1) begin
                    rcyc = c;
                    rpc  = redirect_pc;
                end
            end
            if (nred == 0 && !stall_dispatch) nstall_low++;
            if (halted) nhalt++;
            if (nred > 0 && c == rcyc + 1) begin
                busy_after = busy | stall_dispatch;
                pc_after   = redirect_pc;
            end
            sq_drain_busy = (c >= dlo && c <= dhi);
            if (c == reqc) begin
                rec_req  = 1'b1;
                rec_pc   = 32'hDEAD_BEEF;
                ckpt_tbl = ~make_tbl(ofs);
            end else begin
                rec_req = 1'b0;
            end
            tick();
        end
        sq_drain_busy = 1'b0;
        check({tag, ".squash_count"}, 64'(nsq), 64'd1);
    endtask

    int               rcyc, nred, nstall_low, nwr, nhalt;
    logic [XLEN-1:0]  rpc, pc_after;
    logic [CHK_W-1:0] first_data;
    logic             busy_after;

    initial begin
        // Reset state
        do_reset();
        check_all_zero("reset");

        // 1: recovery with no drain wait
        run_seq("s1", 32'h8000_0000, 1, -1, -1, -1, 1'b0,
                rcyc, nred, rpc, nstall_low, nwr, nhalt, first_data, busy_after, pc_after);
        check("s1.first_data", 64'(first_data), 64'h10_3081);
        check("s1.writes",     64'(nwr),        64'd8);
        check("s1.redir_cyc",  64'(rcyc),       64'd11);
        check("s1.redir_pc",   64'(rpc),        64'h8000_0000);
        check("s1.redir_cnt",  64'(nred),       64'd1);
        check("s1.stall_low",  64'(nstall_low), 64'd0);
        check("s1.busy_after", 64'(busy_after), 64'd0);
        check("s1.pc_hold",    64'(pc_after),   64'h8000_0000);

        // 2: drain busy for 5 cycles starting in the last restore cycle
        run_seq("s2", 32'h0000_1000, 3, 9, 13, -1, 1'b0,
                rcyc, nred, rpc, nstall_low, nwr, nhalt, first_data, busy_after, pc_after);
        check("s2.redir_cyc",  64'(rcyc),       64'd15);
        check("s2.redir_pc",   64'(rpc),        64'h0000_1000);
        check("s2.stall_low",  64'(nstall_low), 64'd0);
        check("s2.writes",     64'(nwr),        64'd8);

        // 3: spurious request with new pc/table during RESTORE
        run_seq("s3", 32'h4000_0040, 5, -1, -1, 4, 1'b0,
                rcyc, nred, rpc, nstall_low, nwr, nhalt, first_data, busy_after, pc_after);
        check("s3.redir_cnt",  64'(nred),       64'd1);
        check("s3.redir_pc",   64'(rpc),        64'h4000_0040);
        check("s3.redir_cyc",  64'(rcyc),       64'd11);
        check("s3.writes",     64'(nwr),        64'd8);

        // 4a: halt alone, then rec_req is ignored until reset
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        check("s4a.halted", 64'(halted),         64'd1);
        check("s4a.stall",  64'(stall_dispatch), 64'd1);
        check("s4a.busy",   64'(busy),           64'd0);
        rec_pc  = 32'h1111_2222;
        rec_req = 1'b1;
        tick(); tick(); tick();
        rec_req = 1'b0;
        check("s4a.halted_hold", 64'(halted),         64'd1);
        check("s4a.stall_hold",  64'(stall_dispatch), 64'd1);
        check("s4a.no_squash",   64'(squash),         64'd0);
        check("s4a.no_wr",       64'(mt_wr_en),       64'd0);
        check("s4a.no_redir",    64'(redirect_valid), 64'd0);
        do_reset();
        check_all_zero("s4a.reset");

        // 4b: halt together with rec_req -> recovery wins
        run_seq("s4b", 32'h0000_2000, 7, -1, -1, -1, 1'b1,
                rcyc, nred, rpc, nstall_low, nwr, nhalt, first_data, busy_after, pc_after);
        check("s4b.redir_cyc", 64'(rcyc),  64'd11);
        check("s4b.redir_pc",  64'(rpc),   64'h0000_2000);
        check("s4b.halted",    64'(nhalt), 64'd0);

        // 5: reset during the 3rd restore cycle
        ckpt_tbl = make_tbl(9);
        rec_pc   = 32'h0000_3000;
        rec_req  = 1'b1;
        tick();
        rec_req = 1'b0;
        tick(); tick(); tick();
        check("s5.in_restore", 64'(mt_wr_en),   64'd1);
        check("s5.base_r2",    64'(mt_wr_base), 64'd8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("s5.abort");
        run_seq("s5r", 32'h0000_4000, 11, -1, -1, -1, 1'b0,
                rcyc, nred, rpc, nstall_low, nwr, nhalt, first_data, busy_after, pc_after);
        check("s5r.first_data", 64'(first_data), 64'(exp_chunk(0, 11)));
        check("s5r.writes",     64'(nwr),        64'd8);
        check("s5r.redir_cyc",  64'(rcyc),       64'd11);
        check("s5r.redir_pc",   64'(rpc),        64'h0000_4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
